// File: rtl/envelope_detector_pkg.sv
// Shared types and constants for the envelope detector: FSM state encoding
// and the width of the burst-end hold counter.
package envelope_detector_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/envelope_detector_moving_sum.sv
// Sliding-window running sum over the last 2^LOG2_LEN magnitude samples.
// Unwritten buffer slots are masked to zero until the window has filled once.
module moving_sum #(
  parameter int WIDTH    = 16,
  parameter int LOG2_LEN = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ivalid,
  input  logic [WIDTH-1:0]          modulus,
  output logic [WIDTH+LOG2_LEN-1:0] sum,
  output logic                      full
);

  localparam int SW  = WIDTH + LOG2_LEN;
  localparam int LEN = 1 << LOG2_LEN;
  localparam logic [LOG2_LEN:0] FILL_MAX = (LOG2_LEN + 1)'(LEN);

  logic [WIDTH-1:0]    mem [LEN];
  logic [LOG2_LEN-1:0] wr_ptr;
  logic [LOG2_LEN:0]   fill_cnt;
  logic [WIDTH-1:0]    oldest;

  assign full   = (fill_cnt == FILL_MAX);
  // Until the window is full the slot under wr_ptr has never been written.
  assign oldest = full ? mem[wr_ptr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (ivalid) begin
      sum    <= sum + SW'(modulus) - SW'(oldest);
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (ivalid) mem[wr_ptr] <= modulus;
  end

endmodule

// File: rtl/envelope_detector.sv
// Windowed-average burst detector with hysteresis and sof/eof pulses.
// Optional PEAK_HOLD_EN adds a 'peak' output tracking the max avg of a burst.
module envelope_detector
  import envelope_detector_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOG2_LEN = 3,
  parameter int HOLD     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ivalid,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] thr_on,
  input  logic [WIDTH-1:0] thr_off,
  output logic             ovalid,
  output logic [WIDTH-1:0] avg,
  output logic             detect,
  output logic             sof,
  output logic             eof
`ifdef PEAK_HOLD_EN
  ,
  output logic [WIDTH-1:0] peak
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(HOLD);

  logic [WIDTH+LOG2_LEN-1:0] sum;
  logic                      full;
  logic                      valid_d;
  logic                      out_fire;
  logic [WIDTH-1:0]          avg_new;

  state_t                    state_q, state_d, eval_state;
  logic [HOLD_W-1:0]         hold_q, hold_d, hold_inc;
  logic                      sof_d, eof_d;

  moving_sum #(
    .WIDTH   (WIDTH),
    .LOG2_LEN(LOG2_LEN)
  ) u_moving_sum (
    .clock  (clock),
    .reset  (reset),
    .ivalid (ivalid),
    .modulus(modulus),
    .sum    (sum),
    .full   (full)
  );

  // Stage 2 fires one edge after the sum absorbed the sample.
  assign out_fire = valid_d & full;
  assign avg_new  = WIDTH'(sum >> LOG2_LEN);
  assign hold_inc = hold_q + 1'b1;
  // The sample that completes the window is judged as a SEARCH sample.
  assign eval_state = (state_q == ST_FILL) ? ST_SEARCH : state_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    if (out_fire) begin
      state_d = eval_state;
      case (eval_state)
        ST_SEARCH: begin
          if (avg_new > thr_on) begin
            state_d = ST_ACTIVE;
            sof_d   = 1'b1;
            hold_d  = '0;
          end
        end
        ST_ACTIVE: begin
          if (avg_new < thr_off) begin
            if (hold_inc == HOLD_C) begin
              state_d = ST_SEARCH;
              eof_d   = 1'b1;
              hold_d  = '0;
            end else begin
              hold_d = hold_inc;
            end
          end else begin
            hold_d = '0;
          end
        end
        default: state_d = eval_state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FILL;
      hold_q  <= '0;
      valid_d <= 1'b0;
      ovalid  <= 1'b0;
      avg     <= '0;
      detect  <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_d <= ivalid;
      ovalid  <= out_fire;
      sof     <= sof_d;
      eof     <= eof_d;
      if (out_fire) begin
        avg    <= avg_new;
        detect <= (state_d == ST_ACTIVE);
      end
    end
  end

`ifdef PEAK_HOLD_EN
  // Loaded on burst start, tracks the maximum while active, held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      peak <= '0;
    end else if (out_fire) begin
      if (sof_d) peak <= avg_new;
      else if (state_q == ST_ACTIVE && avg_new > peak) peak <= avg_new;
    end
  end
`endif

endmodule

// File: doc/envelope_detector.md
# envelope_detector

Consumes the magnitude stream from the I/Q modulus estimator and keeps a sliding-window average of it. Runs a hysteresis state machine on that average to flag signal bursts, with one-cycle start and end pulses. Sits directly downstream of the modulus stage and drives burst gating for the demodulator and AGC logic.

## Interface
- WIDTH, 16, width of the unsigned magnitude input and of the average output
- LOG2_LEN, 3, log2 of the averaging window length (LEN = 2^LOG2_LEN samples)
- HOLD, 4, number of consecutive below-threshold valid samples needed to end a burst (1..255)
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ivalid  in  1  input sample strobe
- modulus  in  WIDTH  unsigned magnitude sample
- thr_on  in  WIDTH  burst start threshold
- thr_off  in  WIDTH  burst end threshold
- ovalid  out  1  average/detect outputs updated this cycle
- avg  out  WIDTH  window mean, sum >> LOG2_LEN (floor)
- detect  out  1  high while in ACTIVE
- sof  out  1  one-cycle pulse on burst start
- eof  out  1  one-cycle pulse on burst end

## Operation
- The window is a LEN-deep circular buffer plus a running sum of WIDTH+LOG2_LEN bits. The sum is unsigned and cannot overflow.
- On each ivalid, the sum is updated as sum + modulus − oldest entry, and the new sample overwrites the oldest entry. The write pointer wraps modulo LEN.
- The fill counter saturates at LEN. Until the window is full, entries not yet written read as 0. No output is produced while filling.
- FSM states: FILL, SEARCH, ACTIVE. The FSM advances only on cycles where ovalid is asserted.
  - FILL -> SEARCH: on the LEN-th valid sample. This sample is also evaluated as a SEARCH sample.
  - SEARCH -> ACTIVE: when avg > thr_on. Asserts sof, and detect rises in the same cycle.
  - In ACTIVE, avg < thr_off increments the hold counter; any other sample clears it.
  - ACTIVE -> SEARCH: when the hold counter reaches HOLD. Asserts eof, detect falls in the same cycle, and the counter clears.
- Comparisons use only the threshold relevant to the current state, so thr_off > thr_on is legal.
- Threshold changes take effect on the next valid sample.
- Reset clears the sum, pointer, fill count, hold counter and FSM (to FILL). All outputs reset to 0. Reset mid-burst produces no eof.
- The buffer contents need no reset, because the fill count masks them.

## Timing
- Two-stage pipeline:
  - The sample accepted at edge k updates the sum at edge k.
  - avg, ovalid, detect, sof and eof are registered at edge k+1.
- ovalid is a copy of ivalid delayed by 2 edges, gated by window-full.
- ivalid gaps are allowed and do not alter results. Outputs hold their values and ovalid is 0 during gaps.
- sof and eof are high only in the ovalid cycle that causes the transition.
- Back-to-back ivalid is sustained at 1 sample per clock.

## Configuration
- PEAK_HOLD_EN defined:
  - Adds output port `peak` [WIDTH-1:0], reset value 0.
  - On sof, peak loads that sample's avg.
  - While ACTIVE, peak keeps the maximum avg seen.
  - After eof, peak holds its value until the next sof.
- PEAK_HOLD_EN undefined: no peak port and no peak logic.

## Structure
- Package envelope_detector_pkg holds the FSM state encoding (FILL, SEARCH, ACTIVE) and the hold-counter width constant (8 bits).
- One sub-module, moving_sum, contains the circular buffer, write pointer, fill counter and running sum. Its outputs are sum and full.
- The FSM, output registers and peak logic sit in the top level.

## Test plan
All cases use WIDTH=16, LOG2_LEN=3, HOLD=4.
- Fill: after reset, 7 valid samples of 100 -> ovalid stays 0. The 8th sample -> ovalid=1, avg=100, two edges after acceptance.
- Detect: thr_on=500, constant 1000 -> detect rises on the first output (avg=1000), with sof high for exactly one cycle.
- Hysteresis end: from the steady 1000 state, with thr_off=300, feed zeros.
  - avg steps 875, 750, …, 250, 125, 0, 0.
  - eof fires on the 9th zero (the 4th sample below threshold), and detect falls in the same cycle.
- Short dip: 3 consecutive samples with avg below thr_off, then avg back above -> no eof, hold counter cleared. A later dip still needs 4 fresh samples.
- Gaps and range: alternate ivalid 1/0 with 0xFFFF input -> avg=0xFFFF with no overflow. Outputs match the contiguous run sample-for-sample.
- Reset mid-burst: assert reset in ACTIVE -> all outputs 0 on the next edge, no eof. 8 new samples are needed before the next ovalid. With PEAK_HOLD_EN, peak reads 0.
